// File: rtl/packet_deserializer.sv
// -----------------------------------------------------------------------------
// packet_deserializer
//
// UART-style receiver for the packetizer's serial line. Each frame is one low
// start bit, eight data bits (LSB first) and one high stop bit. Every bit is
// BAUD_DIVISOR clocks wide. A recovered byte is held in a one-entry
// valid/ready output register. link_ready tells the packetizer when another
// frame can be accepted.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   serial_in   serial line, idle high, unsynchronised
//   rx_data     received byte, valid while rx_valid=1
//   rx_valid    byte available
//   rx_ready    consumer accepts; a transfer happens on rx_valid & rx_ready
//   link_ready  to packetizer tx_ready; high in IDLE with nothing held
//   frame_err   one-cycle pulse when the stop bit samples low
//   overrun     one-cycle pulse when a good frame lands on a pending byte
//   err_count   saturating count of frame_err + overrun events
// -----------------------------------------------------------------------------
module packet_deserializer #(
  parameter int unsigned BAUD_DIVISOR = 5  // clocks per bit, 3..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       link_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  // Mid-bit offset from the detected start edge, and end-of-bit count.
  localparam logic [15:0] HALF = 16'((BAUD_DIVISOR - 1) / 2);
  localparam logic [15:0] LAST = 16'(BAUD_DIVISOR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        sync_1;
  logic        rx_s;

  // Held byte that will not leave on this edge; a new byte cannot load over it.
  logic pending;
  assign pending = rx_valid && !rx_ready;

  assign link_ready = (state == IDLE) && !rx_valid;

  // Two-flop synchroniser. Both flops reset to the idle-high level so that
  // the receiver does not see a false start bit on reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the values from
      // before the edge; blocking here would collapse the two stages into one.
      sync_1 <= serial_in;
      rx_s   <= sync_1;
    end
  end

  // Receive FSM, output register and error accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      // Pulses last one cycle; a transfer empties the output register unless
      // a new byte is loaded further down on the same edge.
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end

        START: begin
          cnt <= cnt + 16'd1;
          if (cnt == HALF) begin
            if (!rx_s) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              // Line went back high before mid-start-bit: a glitch, not a frame.
              state <= IDLE;
            end
          end
        end

        DATA: begin
          cnt <= cnt + 16'd1;
          if (cnt == LAST) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          cnt <= cnt + 16'd1;
          if (cnt == LAST) begin
            if (rx_s) begin
              if (pending) begin
                overrun <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          // A line stuck low must return high before a new start is accepted.
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_deserializer.sv
// -----------------------------------------------------------------------------
// tb_packet_deserializer
//
// Directed bench for packet_deserializer with BAUD_DIVISOR=5 (HALF=2).
// Frames are driven one clock after a rising edge. A monitor on the falling
// edge records every transfer and counts error pulses. Expected values are
// written by hand from the frame timing.
// -----------------------------------------------------------------------------
module tb_packet_deserializer;

  localparam int B = 5;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       link_ready;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;

  packet_deserializer #(.BAUD_DIVISOR(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .link_ready (link_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: transfers and error pulses, sampled mid-cycle.
  logic [7:0] xfer_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  // Drive one level for n clocks; entered and left just after a rising edge.
  task automatic drive_bits(input logic v, input int n);
    serial_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame. stop_low=0 gives a clean stop bit; otherwise the stop bit is
  // held low for stop_low clocks and the line then returns high.
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    drive_bits(1'b0, B);
    for (int k = 0; k < 8; k++) drive_bits(d[k], B);
    if (stop_low == 0) begin
      drive_bits(1'b1, B);
    end else begin
      drive_bits(1'b0, stop_low);
      serial_in = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got_b;
    rst_n     = 1'b0;
    serial_in = 1'b1;
    rx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset state ----
    check("reset_rx_valid", 16'(rx_valid), 16'd0);
    check("reset_rx_data", 16'(rx_data), 16'h00);
    check("reset_err_count", 16'(err_count), 16'd0);
    check("reset_pulses", 16'({frame_err, overrun}), 16'd0);
    rst_n = 1'b1;
    idle_cycles(1);
    check("reset_link_ready", 16'(link_ready), 16'd1);
    idle_cycles(2);

    // ---- single byte: falling edge driven after edge E, t0=E+3, valid at E+51 ----
    fork
      send_frame(8'hA5, 0);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("single_link_ready_busy", 16'(link_ready), 16'd0);
        repeat (30) @(posedge clk);
        #1;
        check("single_valid_before", 16'(rx_valid), 16'd0);
        @(posedge clk);
        #1;
        check("single_valid_at_stop", 16'(rx_valid), 16'd1);
        check("single_data", 16'(rx_data), 16'hA5);
        @(posedge clk);
        #1;
        check("single_valid_one_cycle", 16'(rx_valid), 16'd0);
      end
    join
    idle_cycles(3);
    check("single_err_count", 16'(err_count), 16'd0);
    check("single_xfers", 16'(xfer_q.size()), 16'd1);
    xfer_q.delete();

    // ---- back-to-back frames ----
    fork
      begin
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        send_frame(8'h3C, 0);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        check("b2b_link_ready_f1", 16'(link_ready), 16'd0);
        repeat (50) @(posedge clk);
        #1;
        check("b2b_link_ready_f2", 16'(link_ready), 16'd0);
        repeat (50) @(posedge clk);
        #1;
        check("b2b_link_ready_f3", 16'(link_ready), 16'd0);
      end
    join
    idle_cycles(5);
    check("b2b_xfers", 16'(xfer_q.size()), 16'd3);
    got_b = (xfer_q.size() > 0) ? xfer_q.pop_front() : 8'hEE;
    check("b2b_byte0", 16'(got_b), 16'h00);
    got_b = (xfer_q.size() > 0) ? xfer_q.pop_front() : 8'hEE;
    check("b2b_byte1", 16'(got_b), 16'hFF);
    got_b = (xfer_q.size() > 0) ? xfer_q.pop_front() : 8'hEE;
    check("b2b_byte2", 16'(got_b), 16'h3C);
    check("b2b_errors", 16'(fe_cnt + ov_cnt), 16'd0);
    xfer_q.delete();

    // ---- glitch: low for one clock, START rejects it at E+6 ----
    drive_bits(1'b0, 1);
    serial_in = 1'b1;
    idle_cycles(3);
    check("glitch_link_ready_busy", 16'(link_ready), 16'd0);
    idle_cycles(2);
    check("glitch_link_ready_back", 16'(link_ready), 16'd1);
    idle_cycles(60);
    check("glitch_no_valid", 16'(xfer_q.size()), 16'd0);
    check("glitch_no_frame_err", 16'(fe_cnt), 16'd0);

    // ---- framing error, then a clean frame ----
    send_frame(8'h55, 10);
    idle_cycles(10);
    check("frame_err_pulses", 16'(fe_cnt), 16'd1);
    check("frame_err_count", 16'(err_count), 16'd1);
    check("frame_err_no_xfer", 16'(xfer_q.size()), 16'd0);
    send_frame(8'h12, 0);
    idle_cycles(5);
    got_b = (xfer_q.size() > 0) ? xfer_q.pop_front() : 8'hEE;
    check("after_ferr_byte", 16'(got_b), 16'h12);
    xfer_q.delete();

    // ---- backpressure and overrun ----
    rx_ready = 1'b0;
    send_frame(8'h11, 0);
    idle_cycles(3);
    check("bp_first_valid", 16'(rx_valid), 16'd1);
    check("bp_first_data", 16'(rx_data), 16'h11);
    check("bp_link_ready_low", 16'(link_ready), 16'd0);
    send_frame(8'h22, 0);
    idle_cycles(3);
    check("bp_data_held", 16'(rx_data), 16'h11);
    check("bp_valid_held", 16'(rx_valid), 16'd1);
    check("bp_overrun_pulses", 16'(ov_cnt), 16'd1);
    check("bp_err_count", 16'(err_count), 16'd2);
    rx_ready = 1'b1;
    idle_cycles(4);
    check("bp_single_xfer", 16'(xfer_q.size()), 16'd1);
    got_b = (xfer_q.size() > 0) ? xfer_q.pop_front() : 8'hEE;
    check("bp_xfer_data", 16'(got_b), 16'h11);
    check("bp_valid_cleared", 16'(rx_valid), 16'd0);
    xfer_q.delete();

    // ---- reset mid-DATA with a byte held ----
    rx_ready = 1'b0;
    send_frame(8'h77, 0);
    idle_cycles(3);
    check("rst_pre_valid", 16'(rx_valid), 16'd1);
    fork
      send_frame(8'h5A, 0);
      begin
        repeat (25) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_rx_valid", 16'(rx_valid), 16'd0);
        check("rst_rx_data", 16'(rx_data), 16'h00);
        check("rst_err_count", 16'(err_count), 16'd0);
        check("rst_pulses", 16'({frame_err, overrun}), 16'd0);
      end
    join
    fe_cnt   = 0;
    ov_cnt   = 0;
    rx_ready = 1'b1;
    rst_n    = 1'b1;
    idle_cycles(1);
    check("rst_link_ready", 16'(link_ready), 16'd1);
    idle_cycles(60);
    check("rst_no_valid", 16'(rx_valid), 16'd0);
    check("rst_no_pulses", 16'(fe_cnt + ov_cnt), 16'd0);
    xfer_q.delete();

    // ---- err_count saturation over 300 framing errors ----
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h00, B);
      drive_bits(1'b1, 3);
      if (i == 99) check("sat_count_100", 16'(err_count), 16'd100);
    end
    idle_cycles(5);
    check("sat_frame_err_pulses", 16'(fe_cnt), 16'd300);
    check("sat_err_count", 16'(err_count), 16'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_deserializer.md
# packet_deserializer

Serial receiver that sits directly downstream of the packetizer FSM. It consumes the packetizer's `serial_out` line: one start bit (low), eight data bits LSB first, one stop bit (high), each bit `BAUD_DIVISOR` clocks wide. It recovers each byte and presents it on a one-entry valid/ready output register. It also drives `link_ready` back to the packetizer's `tx_ready` input for flow control.

## Interface
- `BAUD_DIVISOR`, default 5: clocks per bit; must match the transmitter; legal range 3..65535.
- `HALF` (localparam) = (BAUD_DIVISOR-1)/2, integer division: mid-bit sample offset.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `serial_in` input 1: serial line from the packetizer; idle high; asynchronous to nothing but treated as unsynchronised.
- `rx_data` output 8: received byte; valid while `rx_valid`=1.
- `rx_valid` output 1: byte available.
- `rx_ready` input 1: consumer accepts; a transfer occurs on a cycle with `rx_valid`=1 and `rx_ready`=1.
- `link_ready` output 1: to the packetizer `tx_ready`; high when state is IDLE and `rx_valid`=0.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `overrun` output 1: one-cycle pulse when a good frame completes while the held byte is still pending.
- `err_count` output 8: saturating count of frame_err plus overrun events; saturates at 255.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `err_count`=0. The state is IDLE and the synchroniser flops are 1, so `link_ready`=1 one cycle after reset release. Reset mid-frame abandons the frame with no pulse.
- `serial_in` passes through a 2-flop synchroniser; the result is `rx_s`. All decisions use `rx_s`.
- `cnt` is a 16-bit bit-timer; `bit_idx` is 3 bits; `shreg` is 8 bits.
- IDLE: if `rx_s`=0 then `cnt`<=0 and go to START.
- START: increment `cnt`. On the cycle `cnt`==HALF, sample `rx_s`:
  - `rx_s`=0: `cnt`<=0, `bit_idx`<=0, go to DATA.
  - `rx_s`=1: glitch; go to IDLE with no flag.
- DATA: increment `cnt`. On `cnt`==BAUD_DIVISOR-1:
  - `shreg[bit_idx]`<=`rx_s`, `cnt`<=0.
  - If `bit_idx`==7, go to STOP; otherwise `bit_idx`++.
- STOP: increment `cnt`. On `cnt`==BAUD_DIVISOR-1, sample `rx_s`:
  - 1 with no pending byte: load `rx_data`<=`shreg`, `rx_valid`<=1, go to IDLE.
  - 1 with a pending byte: pulse `overrun`, discard `shreg`, go to IDLE.
  - 0: pulse `frame_err`, discard `shreg`, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a stuck-low line from retriggering.
- Pending byte: a byte is pending when `rx_valid`=1 and `rx_ready`=0 on the capture cycle. If `rx_ready`=1 on that same cycle, the old byte transfers, the new byte loads, and `rx_valid` stays 1.
- `rx_valid` clears the cycle after a transfer unless a new byte loads on that edge.
- `rx_data` must not change while `rx_valid`=1 and no transfer is occurring.
- `err_count` increments by 1 per event and holds at 255. Because `frame_err` and `overrun` are mutually exclusive, it never increments by 2.

## Timing
- Define t0 as the edge on which IDLE registers `rx_s`=0. The raw falling edge of `serial_in` precedes t0 by 2–3 clocks because of the synchroniser.
- Start-bit check at edge t0+HALF+1.
- Data bit k (0..7) sampled at edge t0+HALF+1+(k+1)·BAUD_DIVISOR.
- Stop bit sampled at edge t0+HALF+1+9·BAUD_DIVISOR. `rx_valid`, `frame_err`, and `overrun` change on that edge.
- `link_ready` falls on edge t0 (state leaves IDLE). It rises again after the stop edge only if `rx_valid`=0.
- Back-to-back frames: IDLE can detect the next start bit on the edge immediately after the stop-sample edge.
- Output handshake is zero-latency: a transfer completes on the `rx_valid`&`rx_ready` edge.

## Test plan
- **Single byte:** BAUD_DIVISOR=5, send 0xA5 with `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` high exactly 1 cycle, at t0+3+45 → edge t0+48; `err_count`=0.
- **Back-to-back frames:** 0x00, 0xFF, 0x3C with `rx_ready` held 1 → three transfers in order, no errors; `link_ready` low during each frame.
- **Glitch:** `serial_in` low for 1 clock, then high → no `rx_valid`, no `frame_err`; state back in IDLE; `link_ready`=1 within 6 clocks.
- **Framing error:** send 0x55 with the stop bit forced low for 10 clocks, then high → one `frame_err` pulse, no `rx_valid`, `err_count`=1. The next clean 0x12 is received correctly.
- **Backpressure and overrun:** `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `rx_valid` stays 1; one `overrun` pulse at the second stop edge. Raise `rx_ready` → a single transfer of 0x11.
- **Reset and saturation:** assert `rst_n` low mid-DATA → all outputs at reset values immediately, with no pulse. Separately, inject 300 framing errors → `err_count`=255.
